// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit restoring divider for the EX stage.
// It keeps stallreq_for_ex high while a divide is in flight. It returns
// {remainder, quotient} in the cycle ready_o rises.
// Optional feature macro: DIV_SIGNED_EN. When it is defined, signed_div_i selects
// signed division. Otherwise every operation is unsigned.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stallreq_for_ex
);

    typedef enum logic [1:0] {StIdle, StByZero, StOn, StEnd} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q;
    logic [64:0] work_q;
    logic [31:0] divisor_q;
    logic [63:0] result_q;

    logic        start_ok;
    logic [31:0] dividend_abs, divisor_abs;
    logic [32:0] trial;
    logic [64:0] work_step;
    logic [31:0] quot_fix, rem_fix;

    assign start_ok = start_i && !annul_i;

`ifdef DIV_SIGNED_EN
    logic neg_quot_q, neg_rem_q;
    logic neg_quot_in, neg_rem_in;

    // Operand magnitudes and result sign flags, taken only for signed divides.
    always_comb begin
        dividend_abs = opdata1_i;
        divisor_abs  = opdata2_i;
        neg_quot_in  = 1'b0;
        neg_rem_in   = 1'b0;
        if (signed_div_i) begin
            if (opdata1_i[31]) dividend_abs = -opdata1_i;
            if (opdata2_i[31]) divisor_abs  = -opdata2_i;
            neg_quot_in = opdata1_i[31] ^ opdata2_i[31];
            neg_rem_in  = opdata1_i[31];
        end
    end

    // Sign flags are captured when a divide is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else if (state_q == StIdle && start_ok && opdata2_i != 32'd0) begin
            neg_quot_q <= neg_quot_in;
            neg_rem_q  <= neg_rem_in;
        end
    end
`else
    logic unused_signed_div;
    assign unused_signed_div = signed_div_i;

    // Unsigned-only build: operands pass through unchanged.
    always_comb begin
        dividend_abs = opdata1_i;
        divisor_abs  = opdata2_i;
    end
`endif

    // One restoring step. The LSB of work_q is a shift slot, so the first trial
    // already includes the dividend MSB.
    always_comb begin
        trial = work_q[64:32] - {1'b0, divisor_q};
        if (trial[32]) begin
            work_step = {work_q[63:0], 1'b0};
        end else begin
            work_step = {trial[31:0], work_q[31:0], 1'b1};
        end
    end

    // Final quotient and remainder are taken from the post-step value, then sign-corrected.
    always_comb begin
        quot_fix = work_step[31:0];
        rem_fix  = work_step[64:33];
`ifdef DIV_SIGNED_EN
        if (neg_quot_q) quot_fix = -work_step[31:0];
        if (neg_rem_q)  rem_fix  = -work_step[64:33];
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_ok) state_d = (opdata2_i == 32'd0) ? StByZero : StOn;
            end
            StByZero: state_d = StEnd;
            StOn: begin
                if (annul_i)             state_d = StIdle;
                else if (cnt_q == 6'd31) state_d = StEnd;
            end
            StEnd: begin
                if (annul_i || !start_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath: operand capture, iteration, and result latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= 6'd0;
            work_q    <= 65'd0;
            divisor_q <= 32'd0;
            result_q  <= 64'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_ok && opdata2_i != 32'd0) begin
                        divisor_q <= divisor_abs;
                        work_q    <= {32'd0, dividend_abs, 1'b0};
                        cnt_q     <= 6'd0;
                    end
                end
                StByZero: result_q <= 64'd0;
                StOn: begin
                    if (!annul_i) begin
                        work_q <= work_step;
                        cnt_q  <= cnt_q + 6'd1;
                        if (cnt_q == 6'd31) result_q <= {rem_fix, quot_fix};
                    end
                end
                default: ;
            endcase
        end
    end

    assign result_o        = result_q;
    assign ready_o         = (state_q == StEnd);
    assign stallreq_for_ex = !annul_i &&
                             ((state_q == StIdle && start_i) ||
                              state_q == StByZero || state_q == StOn);

endmodule
